// File: rtl/lower_layer_sort_n.sv
// Block sorter: fills N {key,label} pairs, sorts them in place with odd-even
// transposition passes (one pass per cycle), then drains them in order.
module lower_layer_sort_n #(
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 8,
    parameter int N       = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [IDX_W-1:0]       in_idx,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(N):0]     sort_passes,
    output logic [1:0]             fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready/out_valid depend only on registered state, and
    // out_data/out_idx/out_last stay stable while out_valid=1 and out_ready=0.

    localparam int PW  = $clog2(N);
    localparam int PPW = $clog2(N) + 1;
    localparam logic [PW-1:0]  LAST   = PW'(N - 1);
    localparam logic [PPW-1:0] PASS_N = PPW'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SORT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  key [N];
    logic [IDX_W-1:0]   idx [N];
    logic [DATA_W-1:0]  nk  [N];
    logic [IDX_W-1:0]   ni  [N];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PPW-1:0]     pass_cnt;
    logic [PPW-1:0]     pass_next;
    logic               pass_odd;
    logic               even_clean;
    logic               swap_any;
    logic               sort_exit;

    function automatic logic out_of_order(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
        return DESCEND ? (a < b) : (a > b);
    endfunction

    // One transposition pass; pairs within a pass are disjoint, so every
    // compare reads the current buffer directly.
    always_comb begin
        nk       = key;
        ni       = idx;
        swap_any = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if (i[0] == pass_odd && out_of_order(key[i], key[i+1])) begin
                nk[i]    = key[i+1];
                nk[i+1]  = key[i];
                ni[i]    = idx[i+1];
                ni[i+1]  = idx[i];
                swap_any = 1'b1;
            end
        end
    end

    assign pass_next = pass_cnt + PPW'(1);
    // Early exit needs a clean even pass followed by a clean odd pass.
    assign sort_exit = (pass_next == PASS_N) || (pass_odd && !swap_any && even_clean);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pass_cnt    <= '0;
            pass_odd    <= 1'b0;
            even_clean  <= 1'b0;
            sort_passes <= '0;
            done        <= 1'b0;
            for (int i = 0; i < N; i++) begin
                key[i] <= '0;
                idx[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state  <= FILL;
                        wr_ptr <= '0;
                        done   <= 1'b0;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        key[wr_ptr] <= in_data;
                        idx[wr_ptr] <= in_idx;
                        if (wr_ptr == LAST) begin
                            state      <= SORT;
                            pass_cnt   <= '0;
                            pass_odd   <= 1'b0;
                            even_clean <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                    end
                end
                SORT: begin
                    key      <= nk;
                    idx      <= ni;
                    pass_cnt <= pass_next;
                    pass_odd <= ~pass_odd;
                    if (!pass_odd) begin
                        even_clean <= !swap_any;
                    end
                    if (sort_exit) begin
                        state       <= DRAIN;
                        sort_passes <= pass_next;
                        rd_ptr      <= '0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr == LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + PW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == FILL);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (rd_ptr == LAST);
    assign busy      = (state != IDLE);
    assign out_data  = key[rd_ptr];
    assign out_idx   = idx[rd_ptr];
    assign fsm_state = state;

endmodule

// File: tb/tb_lower_layer_sort_n.sv
// Directed bench for lower_layer_sort_n with N=4: one ascending and one
// descending instance share all inputs except load; sel picks whose outputs are checked.
module tb_lower_layer_sort_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_a, load_d;
    logic        in_valid;
    logic [15:0] in_data;
    logic [7:0]  in_idx;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_last_a, busy_a, done_a;
    logic [15:0] out_data_a;
    logic [7:0]  out_idx_a;
    logic [2:0]  sort_passes_a;
    logic [1:0]  fsm_state_a;

    logic        in_ready_d, out_valid_d, out_last_d, busy_d, done_d;
    logic [15:0] out_data_d;
    logic [7:0]  out_idx_d;
    logic [2:0]  sort_passes_d;
    logic [1:0]  fsm_state_d;

    bit sel = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lower_layer_sort_n #(.DATA_W(16), .IDX_W(8), .N(4), .DESCEND(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load_a), .in_valid(in_valid),
        .in_data(in_data), .in_idx(in_idx), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_idx(out_idx_a), .out_last(out_last_a), .busy(busy_a), .done(done_a),
        .sort_passes(sort_passes_a), .fsm_state(fsm_state_a)
    );

    lower_layer_sort_n #(.DATA_W(16), .IDX_W(8), .N(4), .DESCEND(1'b1)) dut_d (
        .clk(clk), .rst_n(rst_n), .load(load_d), .in_valid(in_valid),
        .in_data(in_data), .in_idx(in_idx), .in_ready(in_ready_d),
        .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
        .out_idx(out_idx_d), .out_last(out_last_d), .busy(busy_d), .done(done_d),
        .sort_passes(sort_passes_d), .fsm_state(fsm_state_d)
    );

    wire        o_in_ready  = sel ? in_ready_d  : in_ready_a;
    wire        o_out_valid = sel ? out_valid_d : out_valid_a;
    wire        o_out_last  = sel ? out_last_d  : out_last_a;
    wire        o_busy      = sel ? busy_d      : busy_a;
    wire        o_done      = sel ? done_d      : done_a;
    wire [15:0] o_out_data  = sel ? out_data_d  : out_data_a;
    wire [7:0]  o_out_idx   = sel ? out_idx_d   : out_idx_a;
    wire [2:0]  o_passes    = sel ? sort_passes_d : sort_passes_a;
    wire [1:0]  o_state     = sel ? fsm_state_d : fsm_state_a;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_load;
        if (sel) load_d = 1'b1; else load_a = 1'b1;
        step;
        load_a = 1'b0;
        load_d = 1'b0;
    endtask

    task automatic fill(input logic [63:0] keys, input logic [31:0] idxs, input bit load_in_sort);
        pulse_load;
        chk("fill_in_ready", o_in_ready, 1);
        chk("fill_busy", o_busy, 1);
        chk("fill_done_clear", o_done, 0);
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_data  = keys[16*j +: 16];
            in_idx   = idxs[8*j +: 8];
            step;
        end
        in_valid = 1'b0;
        chk("sort_in_ready", o_in_ready, 0);
        chk("sort_state", o_state, 2);
        if (load_in_sort) pulse_load;
    endtask

    task automatic wait_valid;
        for (int c = 0; c < 40 && !o_out_valid; c++) step;
        chk("first_valid", o_out_valid, 1);
    endtask

    task automatic drain(input logic [63:0] keys, input logic [31:0] idxs,
                         input logic [2:0] passes, input bit stall, input bit junk);
        wait_valid;
        chk("sort_passes", o_passes, passes);
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 16'hffff;
            in_idx   = 8'hff;
        end
        for (int j = 0; j < 4; j++) begin
            chk("out_data", o_out_data, keys[16*j +: 16]);
            chk("out_idx", o_out_idx, idxs[8*j +: 8]);
            chk("out_last", o_out_last, (j == 3));
            if (stall) begin
                step;
                chk("stall_valid", o_out_valid, 1);
                chk("stall_data", o_out_data, keys[16*j +: 16]);
                chk("stall_idx", o_out_idx, idxs[8*j +: 8]);
            end
            out_ready = 1'b1;
            step;
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        chk("end_out_valid", o_out_valid, 0);
        chk("end_done", o_done, 1);
        chk("end_busy", o_busy, 0);
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        load_a    = 1'b0;
        load_d    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_idx    = '0;
        out_ready = 1'b0;
        step;
        step;
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_last", o_out_last, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_passes", o_passes, 0);
        chk("rst_state", o_state, 0);
        chk("rst_buffer", o_out_data, 0);
        rst_n = 1'b1;
        step;

        // Already sorted: clean even + clean odd pass, exit after 2.
        sel = 1'b0;
        fill({16'd4, 16'd3, 16'd2, 16'd1}, {8'd3, 8'd2, 8'd1, 8'd0}, 1'b0);
        drain({16'd4, 16'd3, 16'd2, 16'd1}, {8'd3, 8'd2, 8'd1, 8'd0}, 3'd2, 1'b0, 1'b0);

        // Reverse order; load pulsed during SORT, in_valid junk during DRAIN.
        fill({16'd3, 16'd5, 16'd7, 16'd9}, {8'd3, 8'd2, 8'd1, 8'd0}, 1'b1);
        chk("load_ignored_busy", o_busy, 1);
        drain({16'd9, 16'd7, 16'd5, 16'd3}, {8'd0, 8'd1, 8'd2, 8'd3}, 3'd4, 1'b0, 1'b1);
        step;
        chk("idle_after_junk", o_state, 0);

        // Stability with duplicate keys.
        fill({16'd2, 16'd5, 16'd2, 16'd5}, {8'd3, 8'd2, 8'd1, 8'd0}, 1'b0);
        drain({16'd5, 16'd5, 16'd2, 16'd2}, {8'd2, 8'd0, 8'd3, 8'd1}, 3'd4, 1'b0, 1'b0);

        // Descending instance with stalls on every element.
        sel = 1'b1;
        fill({16'd3, 16'd2, 16'd4, 16'd1}, {8'd3, 8'd2, 8'd1, 8'd0}, 1'b0);
        drain({16'd1, 16'd2, 16'd3, 16'd4}, {8'd0, 8'd2, 8'd3, 8'd1}, 3'd4, 1'b1, 1'b0);

        // Reset in the middle of DRAIN.
        sel = 1'b0;
        fill({16'd3, 16'd6, 16'd1, 16'd8}, {8'd7, 8'd6, 8'd5, 8'd4}, 1'b0);
        wait_valid;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        chk("mid_rst_out_valid", o_out_valid, 0);
        chk("mid_rst_out_last", o_out_last, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_done", o_done, 0);
        chk("mid_rst_passes", o_passes, 0);
        chk("mid_rst_out_data", o_out_data, 0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step;
            seen = seen | o_out_valid;
        end
        out_ready = 1'b0;
        chk("no_valid_after_rst", seen, 0);
        fill({16'd3, 16'd6, 16'd1, 16'd8}, {8'd7, 8'd6, 8'd5, 8'd4}, 1'b0);
        drain({16'd8, 16'd6, 16'd3, 16'd1}, {8'd4, 8'd6, 8'd7, 8'd5}, 3'd4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lower_layer_sort_n.md
LOWER_LAYER_SORT_N -- requirements
Module: lower_layer_sort_n

Interface
REQ-001 Parameter DATA_W, default 16: key (distance) width in bits.
REQ-002 Parameter IDX_W, default 8: label/index width carried with each key.
REQ-003 Parameter N, default 8: elements per block; even, 2..32.
REQ-004 Parameter DESCEND, default 0: 0 sorts ascending, 1 sorts descending.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 load  in  1  start-of-block request; honoured only in IDLE.
REQ-008 in_valid  in  1  input element valid.
REQ-009 in_data  in  DATA_W  input key.
REQ-010 in_idx  in  IDX_W  input label.
REQ-011 in_ready  out  1  block accepts an input element.
REQ-012 out_valid  out  1  sorted element valid.
REQ-013 out_ready  in  1  downstream accepts an output element.
REQ-014 out_data  out  DATA_W  sorted key.
REQ-015 out_idx  out  IDX_W  label travelling with out_data.
REQ-016 out_last  out  1  marks the N-th output element.
REQ-017 busy  out  1  high in FILL, SORT and DRAIN.
REQ-018 done  out  1  level; set after the last drain handshake, cleared when the next load is accepted.
REQ-019 sort_passes  out  $clog2(N)+1  number of compare passes used by the last sort.

Function
REQ-020 The FSM SHALL have states IDLE, FILL, SORT and DRAIN; all outputs SHALL be registered or decoded from registered state.
REQ-021 IDLE: in_ready=0, out_valid=0; load=1 -> FILL next cycle, write pointer=0, done cleared.
REQ-022 FILL: in_ready=1; each in_valid&in_ready writes {in_data,in_idx} to buffer[wr_ptr] and increments wr_ptr.
REQ-023 FILL: the N-th accepted element -> SORT next cycle; in_ready=0 from that cycle.
REQ-024 SORT: one odd-even transposition pass per cycle, starting with the even pass (pairs 0-1, 2-3, ...), then the odd pass (pairs 1-2, 3-4, ...), alternating.
REQ-025 Swap condition: key[i] > key[i+1] (DESCEND=0) or key[i] < key[i+1] (DESCEND=1), strict; labels move with keys; equal keys never swap, so the sort is stable.
REQ-026 SORT ends after N passes, or early after one even pass and the following odd pass both perform zero swaps, whichever comes first; then -> DRAIN.
REQ-027 sort_passes SHALL hold the executed pass count, updated on SORT exit and held until the next SORT exit.
REQ-028 DRAIN: out_valid=1 and out_data/out_idx=buffer[rd_ptr]; rd_ptr increments on out_valid&out_ready; outputs are stable while out_ready=0.
REQ-029 out_last=1 when rd_ptr==N-1; the handshake at out_last -> IDLE next cycle with done=1.
REQ-030 load outside IDLE SHALL be ignored; in_valid outside FILL SHALL be ignored.
REQ-031 Latency: with continuous in_valid and out_ready, the first out_valid SHALL occur at most N+N+1 cycles after the load is accepted.
REQ-032 Pointers SHALL be $clog2(N) bits wide and SHALL never wrap within a block.

Reset
REQ-033 rst_n=0 at a clock edge -> state IDLE; in_ready, out_valid, out_last, busy, done=0; sort_passes=0; pointers=0; buffer cleared to 0.
REQ-034 Reset mid-FILL, SORT or DRAIN aborts the block; no further out_valid until a new load is accepted and N elements are filled.

Verification
REQ-035 N=4, ascending input 1,2,3,4 -> outputs 1,2,3,4; sort_passes=2; out_last on 4; done=1 afterwards.
REQ-036 N=4, reverse input 9,7,5,3 with idx 0..3 -> keys 3,5,7,9 with idx 3,2,1,0; sort_passes=4.
REQ-037 N=4, keys 5,2,5,2 with idx 0..3 -> keys 2,2,5,5 with idx 1,3,0,2 (stability).
REQ-038 DESCEND=1, N=4, input 1,4,2,3 -> outputs 4,3,2,1; out_ready toggled 1/0 -> each element held stable while stalled, no loss or duplication.
REQ-039 load pulsed during SORT, and in_valid held during DRAIN -> both ignored; the block result is unchanged.
REQ-040 rst_n=0 for 1 cycle mid-DRAIN -> all outputs 0 next cycle; a new load with 4 elements sorts correctly.
